// File: rtl/umem_pkg.sv
// Shared types for the byte-serial memory port sequencer.
// Pure declarations: no logic, no latency.
// No flow control lives here.
package umem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int LANE_W = 8;

endpackage

// File: rtl/umem_port_seq.sv
// Host-word to byte-memory sequencer, little-endian, one byte per cycle; optional UMEM_BOUNDS_CHECK_EN.
// Latency accept->rsp_valid: NB+1 (write), NB+2 (read), 1 (out-of-bounds, when checked).
// Backpressure: req_ready only in IDLE; the response holds stable in RESP until rsp_ready.
module umem_port_seq
    import umem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int NB    = DATA_W / LANE_W;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

`ifdef UMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              write_q;

    logic [ADDR_W:0]   last_addr;
    logic              oob;
    logic              cnt_last;
    logic [DATA_W-1:0] rdata_shift;

    // Last byte address is formed one bit wider so a wrapping request is caught.
    assign last_addr = {1'b0, req_addr} + (ADDR_W+1)'(NB - 1);
    assign oob       = BOUNDS_EN && (last_addr > (ADDR_W+1)'(DEPTH - 1));
    assign cnt_last  = (32'(cnt) == NB - 1);
    assign rsp_rdata = rdata_q;

    // Read bytes enter at the top lane; after NB shifts byte 0 sits in the low lane.
    always_comb begin
        rdata_shift = rdata_q >> LANE_W;
        rdata_shift[DATA_W-1 -: LANE_W] = mem_rdata;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            cnt       <= '0;
            base_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            write_q   <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        base_q    <= req_addr;
                        rdata_q   <= '0;
                        cnt       <= '0;
                        if (oob) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state     <= XFER;
                            rsp_err   <= 1'b0;
                            mem_we    <= req_write;
                            mem_re    <= !req_write;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata[LANE_W-1:0];
                            wdata_q   <= req_wdata >> LANE_W;
                        end
                    end
                end
                XFER: begin
                    if (!write_q && cnt != '0) begin
                        rdata_q <= rdata_shift;
                    end
                    if (cnt_last) begin
                        mem_we    <= 1'b0;
                        mem_re    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (write_q) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt       <= cnt + 1'b1;
                        mem_addr  <= base_q + ADDR_W'(cnt) + ADDR_W'(1);
                        mem_wdata <= wdata_q[LANE_W-1:0];
                        wdata_q   <= wdata_q >> LANE_W;
                    end
                end
                DRAIN: begin
                    rdata_q   <= rdata_shift;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_umem_port_seq.sv
// Directed bench for umem_port_seq with a one-cycle-read byte memory model.
module tb_umem_port_seq;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  mem [0:255];
    int          n_re = 0;
    int          checks = 0;
    int          errors = 0;

    umem_port_seq #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            n_re <= n_re + 1;
        end
    end

    task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic hold,
                          output int lat, output logic [31:0] rd, output logic er);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL req_ready_wait: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (!hold) begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_we, mem_re} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {req_ready, rsp_valid, rsp_err, mem_we, mem_re});
        end
        checks++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== 48'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {rsp_rdata, mem_addr, mem_wdata});
        end
        nreset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_fill;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 8'h00, 32'hB4B4_B4B4, 1'b0, lat, rd, er);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL wr_latency: got %0d want 5", lat); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", er); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 00000000", rd); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[k] !== 8'hB4) begin errors++; $display("FAIL wr_mem%0d: got %h want b4", k, mem[k]); end
        end
    endtask

    task automatic test_write_read;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 8'h04, 32'h1122_3344, 1'b0, lat, rd, er);
        checks++;
        if (mem[4] !== 8'h44) begin errors++; $display("FAIL wr_mem4: got %h want 44", mem[4]); end
        checks++;
        if (mem[7] !== 8'h11) begin errors++; $display("FAIL wr_mem7: got %h want 11", mem[7]); end
        do_req(1'b0, 8'h04, 32'h0, 1'b0, lat, rd, er);
        checks++;
        if (lat != 6) begin errors++; $display("FAIL rd_latency: got %0d want 6", lat); end
        checks++;
        if (rd !== 32'h1122_3344) begin errors++; $display("FAIL rd_data: got %h want 11223344", rd); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
        do_req(1'b0, 8'h00, 32'h0, 1'b0, lat, rd, er);
        checks++;
        if (rd !== 32'hB4B4_B4B4) begin errors++; $display("FAIL rd_back: got %h want b4b4b4b4", rd); end
    endtask

`ifdef UMEM_BOUNDS_CHECK_EN
    task automatic test_bounds;
        int lat; int re0; logic [31:0] rd; logic er;
        re0 = n_re;
        do_req(1'b0, 8'hFE, 32'h0, 1'b0, lat, rd, er);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL oob_latency: got %0d want 1", lat); end
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL oob_err: got %b want 1", er); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL oob_rdata: got %h want 00000000", rd); end
        checks++;
        if (n_re != re0) begin errors++; $display("FAIL oob_mem_re: got %0d reads want 0", n_re - re0); end
    endtask
`else
    task automatic test_wrap;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 8'hFE, 32'hAABB_CCDD, 1'b0, lat, rd, er);
        checks++;
        if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== 32'hDDCC_BBAA) begin
            errors++;
            $display("FAIL wrap_mem: got %h want ddccbbaa", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]});
        end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", er); end
    endtask
`endif

    task automatic test_backpressure;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 8'h04, 32'h0, 1'b1, lat, rd, er);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({rsp_valid, req_ready} !== 2'b10 || rsp_rdata !== 32'h1122_3344) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b ready=%b data=%h want valid=1 ready=0 data=11223344",
                         k, rsp_valid, req_ready, rsp_rdata);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid;
        int lat; int nv; logic [31:0] rd; logic er;
        do_req(1'b1, 8'h10, 32'h5A5A_5A5A, 1'b0, lat, rd, er);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 32'hDDCC_BBAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        nreset = 1'b0;
        #1;
        checks++;
        if ({mem_we, rsp_valid, req_ready} !== 3'b000) begin
            errors++; $display("FAIL rstmid_async: got %b want 000", {mem_we, rsp_valid, req_ready});
        end
        @(posedge clk); #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        nv = 0;
        repeat (8) begin
            if (rsp_valid) nv++;
            @(posedge clk); #1;
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d valid cycles want 0", nv); end
        checks++;
        if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hAABB_5A5A) begin
            errors++;
            $display("FAIL rstmid_mem: got %h want aabb5a5a", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]});
        end
    endtask

    initial begin
        test_reset();
        test_write_fill();
        test_write_read();
`ifdef UMEM_BOUNDS_CHECK_EN
        test_bounds();
`else
        test_wrap();
`endif
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/umem_port_seq.md
UMEM_PORT_SEQ -- requirements
Module: umem_port_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, host word width in bits; a multiple of 8, at least 8; NB = DATA_W/8.
REQ-002 SHALL have parameter ADDR_W, default 8, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of implemented memory bytes; at most 2^ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1, req_write input 1 (1=write), req_addr input ADDR_W (byte base address), req_wdata input DATA_W.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_rdata output DATA_W, rsp_err output 1.
REQ-008 SHALL have ports mem_addr output ADDR_W, mem_we output 1, mem_re output 1, mem_wdata output 8, mem_rdata input 8; mem_rdata is valid the cycle after mem_re.

Function
REQ-009 SHALL implement FSM states IDLE, XFER, DRAIN, RESP.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready and latched (write, addr, wdata).
REQ-011 SHALL enter XFER the cycle after accept; a byte counter i runs 0..NB-1, one byte per cycle.
REQ-012 SHALL, in XFER for a write: mem_we=1, mem_addr=base+i, mem_wdata=wdata[8i+7:8i] (little-endian).
REQ-013 SHALL, in XFER for a read: mem_re=1, mem_addr=base+i; capture mem_rdata into rdata byte i-1 on each following cycle; DRAIN (one cycle) captures byte NB-1.
REQ-014 SHALL go XFER->RESP after byte NB-1 for writes, and XFER->DRAIN->RESP for reads.
REQ-015 SHALL hold rsp_valid=1 in RESP with stable rsp_rdata/rsp_err until rsp_valid&&rsp_ready, then return to IDLE; a new request is accepted no earlier than the cycle after.
REQ-016 SHALL produce rsp_valid first at cycle NB+1 (write) or NB+2 (read) after the accept cycle.
REQ-017 SHALL drive rsp_rdata=0 for write responses.
REQ-018 SHALL compute base+i modulo 2^ADDR_W (wrap-around) when the bounds check is not compiled in.
REQ-019 SHALL keep mem_we=mem_re=0 outside XFER, so no byte is ever accessed twice.

Reset
REQ-020 SHALL, while nreset=0, force state IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, asynchronously.
REQ-021 SHALL, on reset mid-transaction, abandon the transaction with no response; bytes already written remain written.
REQ-022 SHALL assert req_ready in the first cycle after nreset deasserts.

Configuration
REQ-023 SHALL, with macro UMEM_BOUNDS_CHECK_EN defined, flag any request where base+NB-1 (computed at ADDR_W+1 bits) exceeds DEPTH-1: no memory access, IDLE->RESP the next cycle, rsp_err=1, rsp_rdata=0.
REQ-024 SHALL, without UMEM_BOUNDS_CHECK_EN, tie rsp_err to 0 and wrap addresses per REQ-018.

Structure
REQ-025 SHALL take the state enum (IDLE, XFER, DRAIN, RESP) and a byte-lane width constant (8) from shared package umem_pkg.
REQ-026 SHALL be a single module with no sub-module; byte counter, FSM and data shift are local.

Verification (DATA_W=32, ADDR_W=8, DEPTH=256, byte-memory model with 1-cycle read)
REQ-027 SHALL cover: write addr 0x00 data 0xB4B4B4B4 -> mem[0..3]=B4, rsp_valid at cycle 5, rsp_err=0.
REQ-028 SHALL cover: write 0x04 0x11223344, then read 0x04 -> mem[4]=0x44, mem[7]=0x11, rsp_rdata=0x11223344 at cycle 6 after read accept.
REQ-029 SHALL cover: without the macro, write 0xFE 0xAABBCCDD -> mem[FE]=DD, mem[FF]=CC, mem[00]=BB, mem[01]=AA.
REQ-030 SHALL cover: with UMEM_BOUNDS_CHECK_EN, read 0xFE -> no mem_re, rsp_err=1, rsp_rdata=0 at cycle 1.
REQ-031 SHALL cover: rsp_ready held low 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout, IDLE after the handshake.
REQ-032 SHALL cover: nreset pulsed low after 2 bytes of a write to 0x10 -> mem[10..11] written, mem[12..13] untouched, no rsp_valid, req_ready=1 after release.
